// File: rtl/famicom_pad_pkg.sv
// Shared constants for the Famicom controller emulator: button indices and default geometry.
// Optional turbo logic in famicom_pad_emu is built when FAMICOM_PAD_TURBO_EN is defined.
package famicom_pad_pkg;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  localparam int unsigned DEF_NUM_PADS  = 2;
  localparam int unsigned DEF_PAD_BITS  = 8;
  localparam int unsigned DEF_SHIFT_LEN = 24;

  localparam int unsigned TURBO_W = 4;

endpackage

// File: rtl/famicom_sync_edge.sv
// Two-flop synchroniser with history flop; provides the synchronised level and a
// registered falling-edge strobe.
module famicom_sync_edge
  import famicom_pad_pkg::*;
(
  input  logic clk_sys,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic hist_q, hist_d;
  logic fall_q, fall_d;

  // The fall strobe is registered so consumers see it three edges after capture.
  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    hist_d = sync_q;
    fall_d = hist_q & ~sync_q;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      hist_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      hist_q <= hist_d;
      fall_q <= fall_d;
    end
  end

  assign level = sync_q;
  assign fall  = fall_q;

endmodule

// File: rtl/famicom_pad_emu.sv
// Famicom/NES controller shift-register emulator for NUM_PADS pads.
// Define FAMICOM_PAD_TURBO_EN to build the A/B turbo phase logic.
module famicom_pad_emu
  import famicom_pad_pkg::*;
#(
  parameter int unsigned NUM_PADS   = DEF_NUM_PADS,
  parameter int unsigned PAD_BITS   = DEF_PAD_BITS,
  parameter int unsigned SHIFT_LEN  = DEF_SHIFT_LEN,
  parameter bit          FILL_AFTER = 1'b0
) (
  input  logic                               clk_sys,
  input  logic                               reset,
  input  logic [NUM_PADS*PAD_BITS-1:0]       pad_buttons,
  input  logic                               famicom_latch,
  input  logic                               famicom_pulse,
  output logic [NUM_PADS-1:0]                famicom_data,
  input  logic [NUM_PADS*2-1:0]              turbo_mask,
  input  logic [TURBO_W-1:0]                 turbo_rate,
  output logic [$clog2(SHIFT_LEN+1)-1:0]     shift_count
);

  localparam int unsigned CNT_W = $clog2(SHIFT_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SHIFT_LEN);

  logic latch_level, latch_fall;
  logic pulse_level, pulse_fall;

  logic [NUM_PADS*PAD_BITS-1:0] eff_c;
  logic [SHIFT_LEN-1:0]         reload_c [NUM_PADS];
  logic [SHIFT_LEN-1:0]         pad_q    [NUM_PADS];
  logic [SHIFT_LEN-1:0]         pad_d    [NUM_PADS];
  logic [CNT_W-1:0]             count_q, count_d;

  famicom_sync_edge u_latch_sync (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .async_in (famicom_latch),
    .level    (latch_level),
    .fall     (latch_fall)
  );

  famicom_sync_edge u_pulse_sync (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .async_in (famicom_pulse),
    .level    (pulse_level),
    .fall     (pulse_fall)
  );

`ifdef FAMICOM_PAD_TURBO_EN
  logic [TURBO_W-1:0] turbo_cnt_q, turbo_cnt_d;
  logic [TURBO_W-1:0] turbo_cnt_inc_c;
  logic               turbo_phase_q, turbo_phase_d;
  logic               unused_c;

  // Phase advances once per completed latch; rate 0 parks it in pass-through.
  always_comb begin
    turbo_cnt_d     = turbo_cnt_q;
    turbo_phase_d   = turbo_phase_q;
    turbo_cnt_inc_c = turbo_cnt_q + TURBO_W'(1);
    if (turbo_rate == '0) begin
      turbo_phase_d = 1'b1;
      turbo_cnt_d   = '0;
    end else if (latch_fall) begin
      if (turbo_cnt_inc_c == turbo_rate) begin
        turbo_phase_d = ~turbo_phase_q;
        turbo_cnt_d   = '0;
      end else begin
        turbo_cnt_d = turbo_cnt_inc_c;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      turbo_cnt_q   <= '0;
      turbo_phase_q <= 1'b1;
    end else begin
      turbo_cnt_q   <= turbo_cnt_d;
      turbo_phase_q <= turbo_phase_d;
    end
  end

  always_comb begin
    eff_c = pad_buttons;
    if (!turbo_phase_q) begin
      for (int n = 0; n < NUM_PADS; n++) begin
        eff_c[n*PAD_BITS + BTN_A] = pad_buttons[n*PAD_BITS + BTN_A] & ~turbo_mask[2*n];
        eff_c[n*PAD_BITS + BTN_B] = pad_buttons[n*PAD_BITS + BTN_B] & ~turbo_mask[2*n + 1];
      end
    end
  end

  assign unused_c = pulse_level;
`else
  logic unused_c;

  assign eff_c    = pad_buttons;
  assign unused_c = ^{turbo_mask, turbo_rate, latch_fall, pulse_level};
`endif

  // Reload image: released (1) above the button field, inverted buttons below.
  always_comb begin
    for (int n = 0; n < NUM_PADS; n++) begin
      reload_c[n]                 = '1;
      reload_c[n][PAD_BITS-1:0]   = ~eff_c[n*PAD_BITS +: PAD_BITS];
    end
  end

  // Latch level wins over a coincident pulse edge.
  always_comb begin
    count_d = count_q;
    for (int n = 0; n < NUM_PADS; n++) begin
      pad_d[n] = pad_q[n];
    end
    if (latch_level) begin
      count_d = '0;
      for (int n = 0; n < NUM_PADS; n++) begin
        pad_d[n] = reload_c[n];
      end
    end else if (pulse_fall) begin
      for (int n = 0; n < NUM_PADS; n++) begin
        pad_d[n] = {FILL_AFTER, pad_q[n][SHIFT_LEN-1:1]};
      end
      if (count_q != CNT_MAX) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      count_q <= '0;
      for (int n = 0; n < NUM_PADS; n++) begin
        pad_q[n] <= '1;
      end
    end else begin
      count_q <= count_d;
      for (int n = 0; n < NUM_PADS; n++) begin
        pad_q[n] <= pad_d[n];
      end
    end
  end

  always_comb begin
    for (int n = 0; n < NUM_PADS; n++) begin
      famicom_data[n] = pad_q[n][0];
    end
  end

  assign shift_count = count_q;

endmodule

// File: tb/tb_famicom_pad_emu.sv
// Directed self-checking bench for famicom_pad_emu at default parameters.
// Turbo sequence is exercised when FAMICOM_PAD_TURBO_EN is defined.
module tb_famicom_pad_emu;

  logic        clk_sys;
  logic        reset;
  logic [15:0] pad_buttons;
  logic        famicom_latch;
  logic        famicom_pulse;
  logic [1:0]  famicom_data;
  logic [3:0]  turbo_mask;
  logic [3:0]  turbo_rate;
  logic [4:0]  shift_count;

  int n_checks = 0;
  int n_fail   = 0;

  famicom_pad_emu dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .pad_buttons   (pad_buttons),
    .famicom_latch (famicom_latch),
    .famicom_pulse (famicom_pulse),
    .famicom_data  (famicom_data),
    .turbo_mask    (turbo_mask),
    .turbo_rate    (turbo_rate),
    .shift_count   (shift_count)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_latch();
    famicom_latch = 1'b1;
    step(4);
    famicom_latch = 1'b0;
    step(4);
  endtask

  task automatic do_pulse();
    famicom_pulse = 1'b1;
    step(3);
    famicom_pulse = 1'b0;
    step(5);
  endtask

  // Expected {pad1, pad0} serial bit after p pulses; fill is 0 at defaults.
  function automatic logic [1:0] exp_bits(input logic [7:0] b0, input logic [7:0] b1, input int p);
    if (p < 8)       return {~b1[p], ~b0[p]};
    else if (p < 24) return 2'b11;
    else             return 2'b00;
  endfunction

  logic [7:0] b0, b1;

  initial begin
    reset         = 1'b1;
    famicom_latch = 1'b0;
    famicom_pulse = 1'b0;
    pad_buttons   = '0;
    turbo_mask    = '0;
    turbo_rate    = '0;
    step(3);
    chk("reset_data", 32'(famicom_data), 32'h3);
    chk("reset_count", 32'(shift_count), 32'h0);
    reset = 1'b0;
    step(2);

    // Full report: button bits, one-fill, then zero fill with saturating count.
    b0 = 8'h09;
    b1 = 8'h82;
    pad_buttons = {b1, b0};
    do_latch();
    chk("rep_bit0", 32'(famicom_data), 32'(exp_bits(b0, b1, 0)));
    chk("rep_cnt0", 32'(shift_count), 32'h0);
    pad_buttons = 16'hFFFF;
    for (int p = 1; p <= 27; p++) begin
      do_pulse();
      chk($sformatf("rep_bit%0d", p), 32'(famicom_data), 32'(exp_bits(b0, b1, p)));
      chk($sformatf("rep_cnt%0d", p), 32'(shift_count), 32'((p > 24) ? 24 : p));
    end

    // Latch held high: pulses are ignored and count clears.
    b0 = 8'h01;
    b1 = 8'h00;
    pad_buttons = {b1, b0};
    famicom_latch = 1'b1;
    step(3);
    for (int i = 0; i < 5; i++) begin
      famicom_pulse = 1'b1;
      step(2);
      famicom_pulse = 1'b0;
      step(2);
    end
    step(3);
    chk("hold_data", 32'(famicom_data), 32'h2);
    chk("hold_cnt", 32'(shift_count), 32'h0);
    famicom_latch = 1'b0;
    step(4);
    chk("hold_cnt_after", 32'(shift_count), 32'h0);

    // Three-edge latency from capture of the pulse fall.
    famicom_pulse = 1'b1;
    step(4);
    famicom_pulse = 1'b0;
    step(1);
    chk("lat_k", 32'(famicom_data), 32'h2);
    step(1);
    chk("lat_k1", 32'(famicom_data), 32'h2);
    step(1);
    chk("lat_k2", 32'(famicom_data), 32'h2);
    step(1);
    chk("lat_k3", 32'(famicom_data), 32'h3);
    chk("lat_cnt", 32'(shift_count), 32'h1);
    step(2);

    // Reset mid-report, then a clean report with new buttons.
    b0 = 8'hF0;
    b1 = 8'h00;
    pad_buttons = {b1, b0};
    do_latch();
    for (int i = 0; i < 4; i++) do_pulse();
    chk("mid_data", 32'(famicom_data), 32'(exp_bits(b0, b1, 4)));
    chk("mid_cnt", 32'(shift_count), 32'h4);
    reset = 1'b1;
    step(1);
    chk("rst_data", 32'(famicom_data), 32'h3);
    chk("rst_cnt", 32'(shift_count), 32'h0);
    reset = 1'b0;
    step(2);
    b0 = 8'h5A;
    b1 = 8'hA5;
    pad_buttons = {b1, b0};
    do_latch();
    chk("fresh_bit0", 32'(famicom_data), 32'(exp_bits(b0, b1, 0)));
    for (int p = 1; p <= 8; p++) begin
      do_pulse();
      chk($sformatf("fresh_bit%0d", p), 32'(famicom_data), 32'(exp_bits(b0, b1, p)));
    end
    chk("fresh_cnt", 32'(shift_count), 32'h8);

`ifdef FAMICOM_PAD_TURBO_EN
    // Turbo on pad0 A at rate 2: pressed,pressed,released,released,...
    pad_buttons = 16'h0101;
    turbo_mask  = 4'b0001;
    turbo_rate  = 4'd2;
    step(2);
    for (int l = 0; l < 8; l++) begin
      do_latch();
      chk($sformatf("turbo_l%0d", l), 32'(famicom_data), (l % 4 < 2) ? 32'h0 : 32'h1);
    end
`else
    // Turbo inputs have no effect in the default build.
    pad_buttons = 16'h0103;
    turbo_mask  = 4'b0011;
    turbo_rate  = 4'd1;
    step(2);
    for (int l = 0; l < 4; l++) begin
      do_latch();
      chk($sformatf("noturbo_l%0d", l), 32'(famicom_data), 32'h0);
      do_pulse();
      chk($sformatf("noturbo_b_l%0d", l), 32'(famicom_data), 32'h2);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
